rat_io_bridge: RTL and testbench

- Parametrised port-mapped I/O bridge between the RAT MCU bus (PORT_ID / OUT_PORT / IO_STRB / IN_PORT) and board peripherals.
- Provides N_IN synchronised input channels, N_OUT readback-capable output registers, and per-channel change-detect interrupts with mask and pending registers that drive the MCU interrupt line.
- Replaces the fixed one-switch / one-LED port decode in the top-level wrapper.

---
 rtl/rat_io_bridge.sv | 142 ++++++++++++++
 tb/tb_rat_io_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rat_io_bridge.sv
// Port-mapped I/O bridge for the RAT MCU: synced inputs, output regs, change IRQs.
// Define IO_DEBOUNCE_EN to add per-channel debounce of DB_CYCLES cycles.
module rat_io_bridge #(
  parameter int              DW          = 8,
  parameter int              N_IN        = 2,
  parameter int              N_OUT       = 2,
  parameter logic [7:0]      IN_BASE     = 8'h20,
  parameter logic [7:0]      OUT_BASE    = 8'h40,
  parameter logic [7:0]      INT_MASK_ID = 8'hF0,
  parameter logic [7:0]      INT_PEND_ID = 8'hF1,
  parameter logic [DW-1:0]   OUT_RST     = '0,
  parameter int              DB_CYCLES   = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [7:0]          PORT_ID,
  input  logic [DW-1:0]       OUT_PORT,
  input  logic                IO_STRB,
  output logic [DW-1:0]       IN_PORT,
  output logic                INTV,
  input  logic [N_IN*DW-1:0]  IN_DATA,
  output logic [N_OUT*DW-1:0] OUT_DATA
);

  if (N_IN < 1 || N_IN > DW || N_OUT < 1 || N_OUT > 16 || DB_CYCLES < 1)
  begin : g_bad_cfg
    $error("rat_io_bridge: illegal parameter set");
  end

  logic [DW-1:0]   sync1 [N_IN];
  logic [DW-1:0]   sync2 [N_IN];
  logic [DW-1:0]   stab  [N_IN];
  logic [DW-1:0]   prev  [N_IN];
  logic [DW-1:0]   outr  [N_OUT];
  logic [N_IN-1:0] chg;
  logic [N_IN-1:0] mask;
  logic [N_IN-1:0] pend;
  logic [N_IN-1:0] clr;
  logic            wr_mask;
  logic            wr_pend;
  logic [DW-1:0]   rd;

  assign wr_mask = IO_STRB && (PORT_ID == INT_MASK_ID);
  assign wr_pend = IO_STRB && (PORT_ID == INT_PEND_ID);
  assign clr     = wr_pend ? OUT_PORT[N_IN-1:0] : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i] <= '0;
        sync2[i] <= '0;
        prev[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync1[i] <= IN_DATA[i*DW +: DW];
        sync2[i] <= sync1[i];
        prev[i]  <= stab[i];
      end
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] cnt [N_IN];

  // S only follows the synchroniser after DB_CYCLES cycles of disagreement
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < N_IN; i++) begin
        stab[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] != stab[i]) begin
          if (cnt[i] == CW'(DB_CYCLES - 1)) begin
            stab[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i]  <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_IN; i++) stab[i] = sync2[i];
  end
`endif

  always_comb begin
    chg = '0;
    for (int i = 0; i < N_IN; i++) chg[i] = (stab[i] != prev[i]);
  end

  // a change-detect set on the same edge wins over a W1C clear
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask <= '0;
      pend <= '0;
      INTV <= 1'b0;
    end else begin
      if (wr_mask) mask <= OUT_PORT[N_IN-1:0];
      pend <= (pend & ~clr) | chg;
      INTV <= |(pend & mask);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int j = 0; j < N_OUT; j++) outr[j] <= OUT_RST;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (IO_STRB && (PORT_ID == OUT_BASE + 8'(j))) outr[j] <= OUT_PORT;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) OUT_DATA[j*DW +: DW] = outr[j];
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (PORT_ID == IN_BASE + 8'(i)) rd = stab[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (PORT_ID == OUT_BASE + 8'(j)) rd = outr[j];
    end
    if (PORT_ID == INT_MASK_ID) rd = DW'(mask);
    if (PORT_ID == INT_PEND_ID) rd = DW'(pend);
  end

  assign IN_PORT = rd;

endmodule

// File: tb/tb_rat_io_bridge.sv
// Self-checking bench for rat_io_bridge: directed steps plus randomized data
// checked against a transaction-level model of registers, S latency and pending.
module tb_rat_io_bridge;

  localparam int DW = 8;
`ifdef IO_DEBOUNCE_EN
  localparam int S_LAT = 2 + 16;
`else
  localparam int S_LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic        INTV;
  logic [15:0] IN_DATA;
  logic [15:0] OUT_DATA;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_out [2];
  logic [7:0] m_in  [2];
  logic [1:0] m_pend;
  logic [1:0] m_mask;

  rat_io_bridge #(
    .DW(8), .N_IN(2), .N_OUT(2),
    .IN_BASE(8'h20), .OUT_BASE(8'h40),
    .INT_MASK_ID(8'hF0), .INT_PEND_ID(8'hF1),
    .OUT_RST(8'hA5), .DB_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_PORT(IN_PORT),
    .INTV(INTV), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] id,
                        input logic [7:0] exp);
    PORT_ID = id;
    #1;
    chk(tag, {24'h0, IN_PORT}, {24'h0, exp});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // one-edge bus write; also advances the register model
  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    @(posedge CLK);
    #2;
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    if (id == 8'h40) m_out[0] = d;
    if (id == 8'h41) m_out[1] = d;
    if (id == 8'hF0) m_mask = d[1:0];
    if (id == 8'hF1) m_pend = m_pend & ~d[1:0];
  endtask

  task automatic set_in(input logic [7:0] v0, input logic [7:0] v1);
    if (v0 != m_in[0]) m_pend[0] = 1'b1;
    if (v1 != m_in[1]) m_pend[1] = 1'b1;
    m_in[0] = v0;
    m_in[1] = v1;
    IN_DATA = {v1, v0};
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] n0;
    logic [7:0] n1;
    logic [1:0] mk;
    int j;

    RESET = 1'b1; IO_STRB = 1'b0; PORT_ID = 8'h00;
    OUT_PORT = 8'h00; IN_DATA = 16'h0000;
    m_out[0] = 8'hA5; m_out[1] = 8'hA5;
    m_in[0] = 8'h00; m_in[1] = 8'h00;
    m_pend = 2'b00; m_mask = 2'b00;

    #1;
    chk("rst_out_data", {16'h0, OUT_DATA}, 32'h0000A5A5);
    chk("rst_intv", {31'h0, INTV}, 32'h0);
    chk_rd("rst_rd40", 8'h40, 8'hA5);
    chk_rd("rst_rd_pend", 8'hF1, 8'h00);
    chk_rd("rst_rd_mask", 8'hF0, 8'h00);
    cyc(2);
    RESET = 1'b0;
    cyc(1);

    wr(8'hF1, 8'hFF);
    wr(8'hF0, 8'h00);

    wr(8'h41, 8'h3C);
    chk("wr41_out", {16'h0, OUT_DATA}, {16'h0, m_out[1], m_out[0]});
    chk_rd("wr41_rd41", 8'h41, 8'h3C);
    chk_rd("wr41_rd40", 8'h40, 8'hA5);

    wr(8'h77, 8'h5A);
    chk("unmapped_wr", {16'h0, OUT_DATA}, {16'h0, m_out[1], m_out[0]});
    chk_rd("unmapped_rd", 8'h77, 8'h00);
    wr(8'h20, 8'h99);
    chk("input_id_wr", {16'h0, OUT_DATA}, {16'h0, m_out[1], m_out[0]});
    chk_rd("input_id_rd", 8'h20, 8'h00);

    for (int k = 0; k < 6; k++) begin
      j = int'($urandom_range(0, 1));
      d = 8'($urandom);
      wr(8'h40 + 8'(j), d);
      chk("rand_out", {16'h0, OUT_DATA}, {16'h0, m_out[1], m_out[0]});
    end
    chk_rd("rand_rd40", 8'h40, m_out[0]);
    chk_rd("rand_rd41", 8'h41, m_out[1]);

    wr(8'hF0, 8'hFF);
    chk_rd("mask_width", 8'hF0, {6'h0, m_mask});
    wr(8'hF1, 8'hFF);
    wr(8'hF0, 8'h01);

    set_in(8'h05, m_in[1]);
    cyc(S_LAT - 1);
    chk_rd("s0_early", 8'h20, 8'h00);
    cyc(1);
    chk_rd("s0_lat", 8'h20, 8'h05);
    chk_rd("pend_not_yet", 8'hF1, 8'h00);
    cyc(1);
    chk_rd("pend_set", 8'hF1, {6'h0, m_pend});
    chk("intv_not_yet", {31'h0, INTV}, 32'h0);
    cyc(1);
    chk("intv_set", {31'h0, INTV}, 32'h1);

    wr(8'hF1, 8'h01);
    cyc(1);
    chk("intv_cleared", {31'h0, INTV}, 32'h0);
    chk_rd("pend_cleared", 8'hF1, {6'h0, m_pend});

    set_in(m_in[0], 8'($urandom_range(1, 255)));
    cyc(S_LAT + 2);
    chk_rd("ch1_pend", 8'hF1, 8'h02);
    chk("ch1_masked", {31'h0, INTV}, 32'h0);
    chk_rd("ch1_rd21", 8'h21, m_in[1]);
    wr(8'hF0, 8'h03);
    cyc(1);
    chk("ch1_unmasked", {31'h0, INTV}, 32'h1);
    wr(8'hF1, 8'hFF);
    cyc(1);
    chk("ch1_cleared", {31'h0, INTV}, 32'h0);

    set_in(~m_in[0], m_in[1]);
    cyc(S_LAT);
    wr(8'hF1, 8'h01);
    m_pend[0] = 1'b1;
    chk_rd("set_beats_clear", 8'hF1, {6'h0, m_pend});
    wr(8'hF1, 8'hFF);

    for (int k = 0; k < 8; k++) begin
      mk = 2'($urandom_range(0, 3));
      wr(8'hF0, {6'h0, mk});
      n0 = ($urandom_range(0, 1) == 1) ? m_in[0] : 8'($urandom);
      n1 = ($urandom_range(0, 1) == 1) ? m_in[1] : 8'($urandom);
      set_in(n0, n1);
      cyc(S_LAT + 3);
      chk_rd("rnd_rd20", 8'h20, m_in[0]);
      chk_rd("rnd_rd21", 8'h21, m_in[1]);
      chk_rd("rnd_pend", 8'hF1, {6'h0, m_pend});
      chk("rnd_intv", {31'h0, INTV}, {31'h0, |(m_pend & m_mask)});
      wr(8'hF1, 8'hFF);
    end

`ifdef IO_DEBOUNCE_EN
    wr(8'hF1, 8'hFF);
    cyc(2);
    n0 = m_in[0];
    IN_DATA[7:0] = ~n0;
    cyc(10);
    IN_DATA[7:0] = n0;
    cyc(30);
    chk_rd("db_glitch_s", 8'h20, n0);
    chk_rd("db_glitch_pend", 8'hF1, 8'h00);
    set_in(~n0, m_in[1]);
    cyc(S_LAT - 1);
    chk_rd("db_hold_early", 8'h20, n0);
    cyc(1);
    chk_rd("db_hold_s", 8'h20, ~n0);
    cyc(1);
    chk_rd("db_hold_pend", 8'hF1, {6'h0, m_pend});
    wr(8'hF1, 8'hFF);
`endif

    wr(8'h40, 8'h12);
    wr(8'hF0, 8'h03);
    set_in(~m_in[0], m_in[1]);
    cyc(S_LAT + 3);
    chk("pre_rst_intv", {31'h0, INTV}, 32'h1);
    #3;
    RESET = 1'b1;
    #1;
    chk("mid_rst_out", {16'h0, OUT_DATA}, 32'h0000A5A5);
    chk("mid_rst_intv", {31'h0, INTV}, 32'h0);
    chk_rd("mid_rst_pend", 8'hF1, 8'h00);
    chk_rd("mid_rst_mask", 8'hF0, 8'h00);
    chk_rd("mid_rst_s0", 8'h20, 8'h00);
    cyc(2);
    RESET = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
